counter_stepper: RTL and testbench
==================================

COUNTER_STEPPER -- requirements
Module: counter_stepper

Interface
REQ-001 SHALL have parameter D_NUM, default 6, the number of BCD digits on the counter side.
REQ-002 SHALL have parameter TIMEOUT, default 63, the maximum number of cycles to wait per step for Ready (used only under REQ-030).
REQ-003 Clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Rst_n  in  1  reset, asynchronous, active-low.
REQ-005 CmdValid  in  1  command offered.
REQ-006 CmdReady  out  1  command accepted this cycle if CmdValid is also high.
REQ-007 CmdOp  in  2  command: 00 step up by CmdArg, 01 step down by CmdArg, 10 load CmdArg, 11 step down until the counter reads zero.
REQ-008 CmdArg  in  D_NUM*4  BCD step count or load value.
REQ-009 Request  out  1  step/load request to the counter.
REQ-010 Dec  out  1  direction to the counter (1 = down).
REQ-011 Set  out  1  load strobe qualifier to the counter.
REQ-012 In  out  D_NUM*4  load value to the counter.
REQ-013 Ready  in  1  counter idle/done.
REQ-014 Out  in  D_NUM*4  current counter value.
REQ-015 Busy, Done, Zero, Err  out  1 each  status bits.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT_ACK, WAIT_DONE and FINISH.
- CmdReady = (state == IDLE).
- Busy = (state != IDLE).
REQ-017 IDLE: on CmdValid, SHALL latch CmdOp and CmdArg and go to the next state as follows.
- Op 00/01 with CmdArg == 0: FINISH.
- Op 11 with Out == 0: FINISH.
- Otherwise: ISSUE.
REQ-018 ISSUE: SHALL wait for Ready == 1, then assert Request for exactly one cycle (registered) and go to WAIT_ACK.
REQ-019 WAIT_ACK: SHALL go to WAIT_DONE when Ready == 0.
REQ-020 WAIT_DONE: on Ready == 1, SHALL decrement the remaining BCD count by one, then branch.
- Op 10: FINISH.
- Op 00/01 with remaining == 0: FINISH.
- Op 11 with Out == 0: FINISH.
- Otherwise: ISSUE.
REQ-021 FINISH: SHALL pulse Done high for exactly one cycle and return to IDLE.
REQ-022 SHALL hold Dec, Set and In stable from the accept edge until Done.
- Dec = 1 for ops 01 and 11.
- Set = 1 for op 10 only.
- In = CmdArg for op 10, else 0.
REQ-023 SHALL ignore CmdValid while Busy; the command is neither latched nor lost-acknowledged.
REQ-024 Latency: with Ready continuously high at accept edge k, the first Request SHALL be high during cycle k+2.
REQ-025 Remaining-count decrement SHALL be BCD-correct (digit borrow 0->9) and SHALL never underflow below 0.
REQ-026 Zero SHALL equal (Out == 0), combinational, independent of state.
REQ-027 Op 11 has no step limit other than the timeout (REQ-030).

Reset
REQ-028 While Rst_n == 0, SHALL force state IDLE and all outputs low, except CmdReady = 1 and Zero per REQ-026.
REQ-029 Reset mid-command SHALL drop Request immediately (asynchronously); no Done is produced.

Configuration
REQ-030 With STEPPER_TIMEOUT_EN defined, a per-step watchdog SHALL run.
- Counter clears on entry to ISSUE.
- Counter counts in WAIT_ACK and WAIT_DONE.
- On reaching TIMEOUT: go to FINISH, Done pulses, Err = 1.
- Err is sticky until the next command is accepted.
REQ-031 Without STEPPER_TIMEOUT_EN, Err SHALL be tied to 0, no watchdog logic is instantiated, and waits are unbounded.

Structure
REQ-032 A shared package SHALL hold the CmdOp encodings, the state enumeration and the BCD digit width constant (4).
REQ-033 The BCD remaining-count decrementer SHALL be a sub-module, bcd_decrementer (D_NUM digits, zero flag out).

Verification
REQ-034 Bench SHALL pair the block with the project Counter (COUNT_DELAY = 3, D_NUM = 6) driven from the same Clk.
- Op 00, Arg 000050, from 0 -> exactly 50 Request pulses, Out = 000050, one Done, Err = 0.
- Then op 01, Arg 000050 -> 50 Requests, Out = 000000, Zero = 1.
- Op 10, Arg 000039 -> one Request with Set = 1, In = 000039, Out = 000039; then op 11 -> 39 Requests, Out = 0, Done.
- Op 00, Arg 0 -> no Request, Done two cycles after accept; op 11 with Out = 0 -> same.
- Second CmdValid held while Busy -> CmdReady = 0 throughout, accepted the cycle after Done.
- Rst_n low during WAIT_DONE -> Request/Busy low immediately, no Done; with STEPPER_TIMEOUT_EN and Ready stuck high after Request -> Err = 1, Done after TIMEOUT cycles.

Source files
------------

// File: rtl/counter_stepper_pkg.sv
// Shared definitions for counter_stepper: command encodings, FSM states,
// BCD digit width and a small command-decoding helper.
package counter_stepper_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    OP_UP           = 2'b00,
    OP_DOWN         = 2'b01,
    OP_LOAD         = 2'b10,
    OP_DOWN_TO_ZERO = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    FINISH    = 3'd4
  } state_t;

  // Ops that drive the counter downwards.
  function automatic logic op_is_down(logic [1:0] op);
    return (op == OP_DOWN) || (op == OP_DOWN_TO_ZERO);
  endfunction

endpackage

// File: rtl/bcd_decrementer.sv
// Saturating BCD decrement by one: digits borrow 0 -> 9, and a zero input
// stays zero. 'zero' flags that the result is all zeros.
module bcd_decrementer
  import counter_stepper_pkg::*;
#(
  parameter int D_NUM = 6
) (
  input  logic [D_NUM*BCD_W-1:0] value,
  output logic [D_NUM*BCD_W-1:0] result,
  output logic                   zero
);

  // Ripple a borrow up from the least-significant digit.
  always_comb begin
    logic borrow;
    borrow = (value != {(D_NUM*BCD_W){1'b0}});
    result = value;
    for (int i = 0; i < D_NUM; i++) begin
      if (borrow) begin
        if (value[i*BCD_W +: BCD_W] == BCD_W'(0)) begin
          result[i*BCD_W +: BCD_W] = BCD_W'(9);
          borrow = 1'b1;
        end else begin
          result[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] - BCD_W'(1);
          borrow = 1'b0;
        end
      end else begin
        result[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W];
        borrow = 1'b0;
      end
    end
  end

  assign zero = (result == {(D_NUM*BCD_W){1'b0}});

endmodule

// File: rtl/counter_stepper.sv
// counter_stepper: turns one step/load command into a sequence of
// Request handshakes towards a BCD counter, then pulses Done.
// Optional feature: define STEPPER_TIMEOUT_EN to add a per-step watchdog
// that aborts a stuck step and raises a sticky Err.
module counter_stepper
  import counter_stepper_pkg::*;
#(
  parameter int D_NUM   = 6,
  parameter int TIMEOUT = 63
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   CmdValid,
  output logic                   CmdReady,
  input  logic [1:0]             CmdOp,
  input  logic [D_NUM*BCD_W-1:0] CmdArg,
  output logic                   Request,
  output logic                   Dec,
  output logic                   Set,
  output logic [D_NUM*BCD_W-1:0] In,
  input  logic                   Ready,
  input  logic [D_NUM*BCD_W-1:0] Out,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Zero,
  output logic                   Err
);

  localparam int VW = D_NUM * BCD_W;

  state_t          state;
  op_t             op;
  logic [VW-1:0]   remaining;
  logic [VW-1:0]   rem_next;
  logic            rem_next_zero;
  logic            out_zero;
  logic            arg_zero;
  logic            cmd_is_step;
  logic            timeout_take;

  bcd_decrementer #(.D_NUM(D_NUM)) u_bcd_decrementer (
    .value  (remaining),
    .result (rem_next),
    .zero   (rem_next_zero)
  );

  assign out_zero    = (Out == {VW{1'b0}});
  assign arg_zero    = (CmdArg == {VW{1'b0}});
  assign cmd_is_step = (CmdOp == OP_UP) || (CmdOp == OP_DOWN);
  assign Zero        = out_zero;
  assign CmdReady    = (state == IDLE);
  assign Busy        = (state != IDLE);

`ifdef STEPPER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] wdog;
  logic            err;
  logic            waiting;

  assign waiting      = (state == WAIT_ACK) || (state == WAIT_DONE);
  // Abort only when the normal transition out of the wait state is not taken.
  assign timeout_take = (wdog == TO_W'(TIMEOUT - 1)) &&
                        (((state == WAIT_ACK) && Ready) || ((state == WAIT_DONE) && !Ready));
  assign Err          = err;

  // Per-step watchdog: cleared while issuing, counts while waiting on the counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wdog <= {TO_W{1'b0}};
    end else if (state == ISSUE) begin
      wdog <= {TO_W{1'b0}};
    end else if (waiting) begin
      wdog <= wdog + TO_W'(1);
    end
  end

  // Sticky error flag, cleared when the next command is accepted.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      err <= 1'b0;
    end else if ((state == IDLE) && CmdValid) begin
      err <= 1'b0;
    end else if (timeout_take) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout_take = 1'b0;
  assign Err          = 1'b0;
`endif

  // Command FSM with registered Request/Done strobes and held counter controls.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      op        <= OP_UP;
      remaining <= {VW{1'b0}};
      Request   <= 1'b0;
      Done      <= 1'b0;
      Dec       <= 1'b0;
      Set       <= 1'b0;
      In        <= {VW{1'b0}};
    end else begin
      Request <= 1'b0;
      Done    <= 1'b0;
      case (state)
        IDLE: begin
          if (CmdValid) begin
            op        <= op_t'(CmdOp);
            remaining <= CmdArg;
            Dec       <= op_is_down(CmdOp);
            Set       <= (CmdOp == OP_LOAD);
            In        <= (CmdOp == OP_LOAD) ? CmdArg : {VW{1'b0}};
            if ((cmd_is_step && arg_zero) || ((CmdOp == OP_DOWN_TO_ZERO) && out_zero)) begin
              state <= FINISH;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (Ready) begin
            Request <= 1'b1;
            state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!Ready) begin
            state <= WAIT_DONE;
          end else if (timeout_take) begin
            state <= FINISH;
          end
        end
        WAIT_DONE: begin
          if (Ready) begin
            remaining <= rem_next;
            if (op == OP_LOAD) begin
              state <= FINISH;
            end else if (op == OP_DOWN_TO_ZERO) begin
              state <= out_zero ? FINISH : ISSUE;
            end else begin
              state <= rem_next_zero ? FINISH : ISSUE;
            end
          end else if (timeout_take) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_stepper.sv
// Bench for counter_stepper paired with a behavioural model of the project
// BCD counter (COUNT_DELAY = 3, D_NUM = 6). Expected results are queued when a
// command is issued and checked by a monitor when Done appears.
module tb_counter_stepper;
  import counter_stepper_pkg::*;

  localparam int D_NUM       = 6;
  localparam int TIMEOUT     = 63;
  localparam int VW          = D_NUM * BCD_W;
  localparam int COUNT_DELAY = 3;

  logic          Clk;
  logic          Rst_n;
  logic          CmdValid;
  logic          CmdReady;
  logic [1:0]    CmdOp;
  logic [VW-1:0] CmdArg;
  logic          Request;
  logic          Dec;
  logic          Set;
  logic [VW-1:0] In;
  logic          Ready;
  logic [VW-1:0] Out;
  logic          Busy;
  logic          Done;
  logic          Zero;
  logic          Err;

  counter_stepper #(.D_NUM(D_NUM), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdArg(CmdArg), .Request(Request), .Dec(Dec), .Set(Set),
    .In(In), .Ready(Ready), .Out(Out), .Busy(Busy), .Done(Done),
    .Zero(Zero), .Err(Err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int cyc;
  initial begin
    cyc = 0;
    forever begin
      @(posedge Clk);
      cyc++;
    end
  end

  // ---------------- counter model ----------------
  int   cnt_val;
  int   cnt_delay;
  logic cnt_rst;
  logic stuck_ready;

  function automatic logic [VW-1:0] to_bcd(int v);
    logic [VW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D_NUM; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(logic [VW-1:0] b);
    int r;
    r = 0;
    for (int i = D_NUM - 1; i >= 0; i--) r = r * 10 + int'(b[i*4 +: 4]);
    return r;
  endfunction

  assign Out = to_bcd(cnt_val);

  // Counter: takes a Request while Ready, stays busy COUNT_DELAY cycles, then applies it.
  always @(posedge Clk) begin
    if (cnt_rst) begin
      Ready     <= 1'b1;
      cnt_val   <= 0;
      cnt_delay <= 0;
    end else if (stuck_ready) begin
      Ready <= 1'b1;
    end else if (Ready) begin
      if (Request) begin
        Ready     <= 1'b0;
        cnt_delay <= COUNT_DELAY;
      end
    end else begin
      if (cnt_delay == 1) begin
        Ready <= 1'b1;
        if (Set)      cnt_val <= from_bcd(In);
        else if (Dec) cnt_val <= (cnt_val == 0) ? 999999 : cnt_val - 1;
        else          cnt_val <= (cnt_val == 999999) ? 0 : cnt_val + 1;
      end
      cnt_delay <= cnt_delay - 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string         name;
    int            reqs;
    logic [VW-1:0] out;
    logic          err;
    logic          dec;
    logic          set;
    logic [VW-1:0] in_val;
    int            req_lat;
    int            done_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp;
  int   n_fail;
  int   req_cnt, first_req_cyc, stab_err, rdy_err, accept_cyc, last_done_cyc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(string name, int reqs, logic [VW-1:0] out, logic err, logic dec,
                      logic set, logic [VW-1:0] in_val, int req_lat, int done_lat);
    exp_t e;
    e.name = name; e.reqs = reqs; e.out = out; e.err = err; e.dec = dec;
    e.set = set; e.in_val = in_val; e.req_lat = req_lat; e.done_lat = done_lat;
    sb.push_back(e);
  endtask

  // Monitor: sample between edges, count Requests, check the queued result on Done.
  initial begin
    req_cnt = 0; first_req_cyc = 0; stab_err = 0; rdy_err = 0;
    accept_cyc = 0; last_done_cyc = 0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        req_cnt = 0; stab_err = 0; rdy_err = 0;
      end else begin
        if (Request) begin
          req_cnt++;
          if (req_cnt == 1) first_req_cyc = cyc;
        end
        if (Busy) begin
          if (CmdReady) rdy_err++;
          if (sb.size() > 0)
            if (Dec !== sb[0].dec || Set !== sb[0].set || In !== sb[0].in_val) stab_err++;
        end
        if (Done) begin
          if (sb.size() == 0) begin
            chk("done_without_command", 32'(sb.size()), 32'd1);
          end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_requests"}, 32'(req_cnt), 32'(mon_e.reqs));
            chk({mon_e.name, "_out"}, 32'(Out), 32'(mon_e.out));
            chk({mon_e.name, "_err"}, 32'(Err), 32'(mon_e.err));
            chk({mon_e.name, "_zero"}, 32'(Zero), 32'(mon_e.out == '0));
            chk({mon_e.name, "_dec"}, 32'(Dec), 32'(mon_e.dec));
            chk({mon_e.name, "_set"}, 32'(Set), 32'(mon_e.set));
            chk({mon_e.name, "_in"}, 32'(In), 32'(mon_e.in_val));
            chk({mon_e.name, "_ctrl_changed_while_busy"}, 32'(stab_err), 32'd0);
            chk({mon_e.name, "_cmdready_while_busy"}, 32'(rdy_err), 32'd0);
            if (mon_e.req_lat >= 0)
              chk({mon_e.name, "_first_request_edges"}, 32'(first_req_cyc - accept_cyc),
                  32'(mon_e.req_lat));
            if (mon_e.done_lat >= 0)
              chk({mon_e.name, "_done_edges"}, 32'(cyc - accept_cyc), 32'(mon_e.done_lat));
          end
          last_done_cyc = cyc;
          req_cnt = 0; stab_err = 0; rdy_err = 0;
        end
        if (CmdValid && CmdReady) accept_cyc = cyc + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Offer a command from just after a rising edge and hold it until accepted.
  task automatic issue(logic [1:0] op, logic [VW-1:0] arg);
    bit ok;
    ok = 1'b0;
    @(posedge Clk); #1;
    CmdOp = op; CmdArg = arg; CmdValid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk);
      if (CmdReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'(CmdReady), 32'd1);
    @(posedge Clk); #1;
    CmdValid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (sb.size() == 0) break;
      @(negedge Clk);
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Start a step, then reset 'extra' half-cycle samples after the first Request.
  task automatic reset_abort(int extra, string name);
    bit seen;
    seen = 1'b0;
    issue(OP_UP, 24'h000005);
    for (int i = 0; i < 100; i++) begin
      if (Request) begin
        seen = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    chk({name, "_request_seen"}, 32'(seen), 32'd1);
    repeat (extra) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk({name, "_request"}, 32'(Request), 32'd0);
    chk({name, "_busy"}, 32'(Busy), 32'd0);
    chk({name, "_cmdready"}, 32'(CmdReady), 32'd1);
    chk({name, "_done"}, 32'(Done), 32'd0);
    repeat (3) @(negedge Clk);
    @(posedge Clk); #1 Rst_n = 1'b1;
    repeat (10) @(negedge Clk);
    chk({name, "_busy_after"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    Rst_n = 1'b0; cnt_rst = 1'b1; stuck_ready = 1'b0;
    CmdValid = 1'b0; CmdOp = 2'b00; CmdArg = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_cmdready", 32'(CmdReady), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_request", 32'(Request), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_dec_set", 32'({Dec, Set}), 32'd0);
    chk("rst_in", 32'(In), 32'd0);
    chk("rst_zero", 32'(Zero), 32'd1);
    cnt_rst = 1'b0;
    @(posedge Clk); #1 Rst_n = 1'b1;

    push("up50", 50, 24'h000050, 1'b0, 1'b0, 1'b0, 24'h0, 1, -1);
    issue(OP_UP, 24'h000050);   wait_idle();
    push("down50", 50, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h0, 1, -1);
    issue(OP_DOWN, 24'h000050); wait_idle();
    push("load39", 1, 24'h000039, 1'b0, 1'b0, 1'b1, 24'h000039, 1, -1);
    issue(OP_LOAD, 24'h000039); wait_idle();
    push("downzero39", 39, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h0, 1, -1);
    issue(OP_DOWN_TO_ZERO, 24'h000005); wait_idle();
    push("up_arg0", 0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h0, -1, 1);
    issue(OP_UP, 24'h000000); wait_idle();
    push("downzero_at0", 0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h0, -1, 1);
    issue(OP_DOWN_TO_ZERO, 24'h000099); wait_idle();

    push("load120", 1, 24'h000120, 1'b0, 1'b0, 1'b1, 24'h000120, -1, -1);
    issue(OP_LOAD, 24'h000120); wait_idle();
    push("down100_borrow", 100, 24'h000020, 1'b0, 1'b1, 1'b0, 24'h0, -1, -1);
    issue(OP_DOWN, 24'h000100); wait_idle();
    push("up10", 10, 24'h000030, 1'b0, 1'b0, 1'b0, 24'h0, -1, -1);
    issue(OP_UP, 24'h000010); wait_idle();

    push("first_of_pair", 3, 24'h000033, 1'b0, 1'b0, 1'b0, 24'h0, -1, -1);
    push("held_second", 2, 24'h000031, 1'b0, 1'b1, 1'b0, 24'h0, -1, -1);
    issue(OP_UP, 24'h000003);
    issue(OP_DOWN, 24'h000002);
    chk("held_accept_after_done", 32'(accept_cyc), 32'(last_done_cyc + 1));
    wait_idle();

    reset_abort(0, "rst_in_wait_ack");
    reset_abort(2, "rst_in_wait_done");
    push("reload7", 1, 24'h000007, 1'b0, 1'b0, 1'b1, 24'h000007, -1, -1);
    issue(OP_LOAD, 24'h000007); wait_idle();

`ifdef STEPPER_TIMEOUT_EN
    stuck_ready = 1'b1;
    push("timeout", 1, 24'h000007, 1'b1, 1'b0, 1'b0, 24'h0, 1, TIMEOUT + 2);
    issue(OP_UP, 24'h000001); wait_idle();
    repeat (3) @(negedge Clk);
    chk("err_sticky", 32'(Err), 32'd1);
    stuck_ready = 1'b0;
    repeat (2) @(negedge Clk);
    push("after_timeout", 1, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h0, -1, -1);
    issue(OP_LOAD, 24'h000000);
    chk("err_cleared_on_accept", 32'(Err), 32'd0);
    wait_idle();
`endif

    repeat (5) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
